// File: rtl/mm_verify_tx_sched_pkg.sv
// Shared MAC-merge definitions: scheduler state encodings, verify/respond
// mPacket framing constants and the byte-wide CRC-32 update.
package mm_verify_tx_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SMD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_MCRC     = 3'd4,
    ST_IPG      = 3'd5
  } tx_state_e;

  localparam logic [7:0]  SMD_V          = 8'h07;
  localparam logic [7:0]  SMD_R          = 8'h19;
  localparam logic [7:0]  PREAMBLE_OCTET = 8'h55;
  localparam logic [31:0] MCRC_XOR       = 32'h0000FFFF;
  // IEEE 802.3 polynomial 0x04C11DB7 in bit-reversed form (LSB-first shifting)
  localparam logic [31:0] CRC32_POLY     = 32'hEDB88320;

  localparam logic [6:0] PREAMBLE_LEN = 7'd7;
  localparam logic [6:0] DATA_LEN     = 7'd60;
  localparam logic [6:0] MCRC_LEN     = 7'd4;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mm_crc32_byte.sv
// Byte-wide running CRC-32 register; clear presets to all-ones, enable folds
// in one octet per cycle.
module mm_crc32_byte
  import mm_verify_tx_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset_begin,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  // CRC state register
  always_ff @(posedge clk) begin
    if (reset_begin) begin
      crc <= 32'h00000000;
    end else if (clr) begin
      crc <= 32'hFFFFFFFF;
    end else if (en) begin
      crc <= crc32_byte(crc, data);
    end else begin
      crc <= crc;
    end
  end

endmodule

// File: rtl/mm_verify_tx_sched.sv
// MAC-merge verify/respond mPacket transmit scheduler with verify timer.
// Outputs are registered and lag the state register by one cycle.
module mm_verify_tx_sched
  import mm_verify_tx_sched_pkg::*;
#(
  parameter int unsigned IPG_OCTETS          = 12,
  parameter int unsigned VERIFY_TIMER_CYCLES = 1250000
) (
  input  logic       clk,
  input  logic       reset_begin,
  input  logic       link_fail,
  input  logic       send_v,
  input  logic       send_r,
  input  logic       exp_busy,
  input  logic       pmac_busy,
  input  logic       verify_timer_start,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       mv_busy,
  output logic       send_v_done,
  output logic       send_r_done,
  output logic       verify_timer_done
);

  localparam int TW = (VERIFY_TIMER_CYCLES > 1) ? $clog2(VERIFY_TIMER_CYCLES) : 1;
  localparam logic [6:0] IPG_LAST = 7'(IPG_OCTETS - 1);

  tx_state_e   state_r, state_next_s;
  logic [6:0]  cnt_r, cnt_next_s;
  logic        resp_sel_r;
  logic        start_s, last_ipg_s, crc_clr_s, crc_en_s;
  logic [31:0] crc_s, mcrc_s;
  logic [7:0]  mcrc_octet_s;
  logic [TW-1:0] timer_cnt_r;
  logic        timer_run_r;

  mm_crc32_byte u_crc (
    .clk         (clk),
    .reset_begin (reset_begin),
    .clr         (crc_clr_s),
    .en          (crc_en_s),
    .data        (8'h00),
    .crc         (crc_s)
  );

  assign mcrc_s       = ~crc_s ^ MCRC_XOR;
  assign mcrc_octet_s = mcrc_s[{cnt_r[1:0], 3'b000} +: 8];

  // Next-state and octet counter sequencing
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    start_s      = 1'b0;
    last_ipg_s   = 1'b0;
    crc_clr_s    = 1'b0;
    crc_en_s     = 1'b0;
    if (link_fail) begin
      state_next_s = ST_IDLE;
      cnt_next_s   = 7'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          crc_clr_s = 1'b1;
          if ((send_r || send_v) && !exp_busy && !pmac_busy) begin
            start_s      = 1'b1;
            state_next_s = ST_PREAMBLE;
            cnt_next_s   = 7'd0;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_PREAMBLE: begin
          if (cnt_r == PREAMBLE_LEN - 7'd1) begin
            state_next_s = ST_SMD;
            cnt_next_s   = 7'd0;
          end else begin
            cnt_next_s = cnt_r + 7'd1;
          end
        end
        ST_SMD: begin
          state_next_s = ST_DATA;
          cnt_next_s   = 7'd0;
        end
        ST_DATA: begin
          crc_en_s = 1'b1;
          if (cnt_r == DATA_LEN - 7'd1) begin
            state_next_s = ST_MCRC;
            cnt_next_s   = 7'd0;
          end else begin
            cnt_next_s = cnt_r + 7'd1;
          end
        end
        ST_MCRC: begin
          if (cnt_r == MCRC_LEN - 7'd1) begin
            state_next_s = ST_IPG;
            cnt_next_s   = 7'd0;
          end else begin
            cnt_next_s = cnt_r + 7'd1;
          end
        end
        ST_IPG: begin
          if (cnt_r == IPG_LAST) begin
            last_ipg_s   = 1'b1;
            state_next_s = ST_IDLE;
            cnt_next_s   = 7'd0;
          end else begin
            cnt_next_s = cnt_r + 7'd1;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
          cnt_next_s   = 7'd0;
        end
      endcase
    end
  end

  // State, octet counter and respond-select registers
  always_ff @(posedge clk) begin
    if (reset_begin) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 7'd0;
      resp_sel_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if (start_s) begin
        resp_sel_r <= send_r;
      end
    end
  end

  // Registered transmit outputs; mv_busy also covers the trailing done cycle
  always_ff @(posedge clk) begin
    if (reset_begin) begin
      tx_en       <= 1'b0;
      tx_data     <= 8'h00;
      mv_busy     <= 1'b0;
      send_v_done <= 1'b0;
      send_r_done <= 1'b0;
    end else begin
      tx_en   <= 1'b0;
      tx_data <= 8'h00;
      if (!link_fail) begin
        case (state_r)
          ST_PREAMBLE: begin
            tx_en   <= 1'b1;
            tx_data <= PREAMBLE_OCTET;
          end
          ST_SMD: begin
            tx_en   <= 1'b1;
            tx_data <= resp_sel_r ? SMD_R : SMD_V;
          end
          ST_DATA: begin
            tx_en   <= 1'b1;
            tx_data <= 8'h00;
          end
          ST_MCRC: begin
            tx_en   <= 1'b1;
            tx_data <= mcrc_octet_s;
          end
          default: begin
            tx_en   <= 1'b0;
            tx_data <= 8'h00;
          end
        endcase
      end
      mv_busy     <= (state_next_s != ST_IDLE) || last_ipg_s;
      send_r_done <= last_ipg_s && resp_sel_r;
      send_v_done <= last_ipg_s && !resp_sel_r;
    end
  end

  // Verify timer: done rises VERIFY_TIMER_CYCLES cycles after the start pulse
  always_ff @(posedge clk) begin
    if (reset_begin || link_fail) begin
      timer_cnt_r       <= '0;
      timer_run_r       <= 1'b0;
      verify_timer_done <= 1'b0;
    end else if (verify_timer_start) begin
      timer_cnt_r       <= TW'(VERIFY_TIMER_CYCLES - 1);
      timer_run_r       <= 1'b1;
      verify_timer_done <= 1'b0;
    end else if (timer_run_r) begin
      if (timer_cnt_r <= TW'(1)) begin
        timer_cnt_r       <= '0;
        timer_run_r       <= 1'b0;
        verify_timer_done <= 1'b1;
      end else begin
        timer_cnt_r <= timer_cnt_r - TW'(1);
      end
    end else begin
      timer_cnt_r <= timer_cnt_r;
    end
  end

endmodule

// File: tb/tb_mm_verify_tx_sched.sv
// Directed bench for mm_verify_tx_sched: an octet scoreboard checks every
// transmitted octet; directed steps check timing, done pulses and the timer.
module tb_mm_verify_tx_sched;

  logic       clk;
  logic       reset_begin, link_fail, send_v, send_r, exp_busy, pmac_busy, verify_timer_start;
  logic       tx_en, mv_busy, send_v_done, send_r_done, verify_timer_done;
  logic [7:0] tx_data;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] mcrc_exp;
  int en_cnt, busy_lo, v_n, r_n, v_at, r_at, hits;

  mm_verify_tx_sched #(.IPG_OCTETS(12), .VERIFY_TIMER_CYCLES(100)) dut (
    .clk(clk), .reset_begin(reset_begin), .link_fail(link_fail),
    .send_v(send_v), .send_r(send_r), .exp_busy(exp_busy), .pmac_busy(pmac_busy),
    .verify_timer_start(verify_timer_start), .tx_en(tx_en), .tx_data(tx_data),
    .mv_busy(mv_busy), .send_v_done(send_v_done), .send_r_done(send_r_done),
    .verify_timer_done(verify_timer_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge and score any transmitted octet
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (tx_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("tx_unexpected", 32'(tx_en), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("tx_octet", 32'(tx_data), 32'(e));
      end
    end else begin
      chk("tx_idle_zero", 32'(tx_data), 32'd0);
    end
  endtask

  task automatic watch(input int n);
    en_cnt = 0; busy_lo = 0; v_n = 0; r_n = 0; v_at = -1; r_at = -1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (tx_en === 1'b1) en_cnt++;
      if (mv_busy !== 1'b1) busy_lo++;
      if (send_v_done === 1'b1) begin v_n++; v_at = i; end
      if (send_r_done === 1'b1) begin r_n++; r_at = i; end
    end
  endtask

  task automatic push_pkt(input bit r, input int n);
    logic [7:0] o;
    for (int i = 0; i < n; i++) begin
      if (i < 7) o = 8'h55;
      else if (i == 7) o = r ? 8'h19 : 8'h07;
      else if (i < 68) o = 8'h00;
      else o = mcrc_exp[(i-68)*8 +: 8];
      exp_q.push_back(o);
    end
  endtask

  task automatic timer_window(input int from, input int to);
    hits = 0;
    for (int t = from; t <= to; t++) begin
      tick();
      if (verify_timer_done !== 1'b0) hits++;
    end
  endtask

  initial begin
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 480; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    mcrc_exp = ~c ^ 32'h0000FFFF;

    reset_begin = 1'b1; link_fail = 1'b0; send_v = 1'b1; send_r = 1'b0;
    exp_busy = 1'b0; pmac_busy = 1'b0; verify_timer_start = 1'b0;
    repeat (3) tick();
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_mv_busy", 32'(mv_busy), 32'd0);
    chk("rst_dones", 32'({send_v_done, send_r_done, verify_timer_done}), 32'd0);
    reset_begin = 1'b0; send_v = 1'b0;
    tick();
    chk("idle_mv_busy", 32'(mv_busy), 32'd0);

    // Verify mPacket; request withdrawn once the packet is under way
    send_v = 1'b1;
    tick();
    chk("v_start_busy", 32'(mv_busy), 32'd1);
    chk("v_start_no_tx", 32'(tx_en), 32'd0);
    push_pkt(1'b0, 72);
    send_v = 1'b0;
    watch(84);
    chk("v_tx_cycles", 32'(en_cnt), 32'd72);
    chk("v_busy_held", 32'(busy_lo), 32'd0);
    chk("v_done_cycle", 32'(v_at), 32'd84);
    chk("v_done_count", 32'(v_n), 32'd1);
    chk("v_no_r_done", 32'(r_n), 32'd0);
    tick();
    chk("v_after_busy", 32'(mv_busy), 32'd0);

    // Both requests: respond first, verify serviced by the next packet
    send_v = 1'b1; send_r = 1'b1;
    tick();
    chk("vr_start_busy", 32'(mv_busy), 32'd1);
    push_pkt(1'b1, 72);
    push_pkt(1'b0, 72);
    send_r = 1'b0;
    watch(84);
    chk("vr_r_done_cycle", 32'(r_at), 32'd84);
    chk("vr_no_v_done", 32'(v_n), 32'd0);
    chk("vr_r_tx_cycles", 32'(en_cnt), 32'd72);
    tick();
    chk("vr_second_busy", 32'(mv_busy), 32'd1);
    chk("vr_second_no_tx", 32'(tx_en), 32'd0);
    send_v = 1'b0;
    watch(84);
    chk("vr_v_done_cycle", 32'(v_at), 32'd84);
    chk("vr_no_r_done", 32'(r_n), 32'd0);
    chk("vr_v_tx_cycles", 32'(en_cnt), 32'd72);
    tick();

    // Express MAC busy blocks start; busy inputs ignored once started
    exp_busy = 1'b1; send_v = 1'b1;
    watch(20);
    chk("exp_hold_no_tx", 32'(en_cnt), 32'd0);
    chk("exp_hold_not_busy", 32'(busy_lo), 32'd20);
    exp_busy = 1'b0;
    tick();
    chk("exp_release_start", 32'(mv_busy), 32'd1);
    push_pkt(1'b0, 72);
    send_v = 1'b0; exp_busy = 1'b1; pmac_busy = 1'b1;
    watch(84);
    chk("exp_pkt_done", 32'(v_at), 32'd84);
    chk("exp_pkt_tx_cycles", 32'(en_cnt), 32'd72);
    exp_busy = 1'b0; pmac_busy = 1'b0;
    tick();

    // link_fail while DATA octet 30 is on the wire
    send_r = 1'b1;
    tick();
    chk("lf_start_busy", 32'(mv_busy), 32'd1);
    push_pkt(1'b1, 39);
    repeat (39) tick();
    link_fail = 1'b1; send_r = 1'b0;
    tick();
    chk("lf_tx_off", 32'(tx_en), 32'd0);
    chk("lf_busy_off", 32'(mv_busy), 32'd0);
    link_fail = 1'b0;
    watch(100);
    chk("lf_quiet_tx", 32'(en_cnt), 32'd0);
    chk("lf_quiet_busy", 32'(busy_lo), 32'd100);
    chk("lf_no_done", 32'(v_n + r_n), 32'd0);

    // Reset mid-packet truncates without a done pulse
    send_v = 1'b1;
    tick();
    chk("rp_start_busy", 32'(mv_busy), 32'd1);
    push_pkt(1'b0, 19);
    send_v = 1'b0;
    repeat (19) tick();
    reset_begin = 1'b1;
    tick();
    chk("rp_tx_off", 32'(tx_en), 32'd0);
    chk("rp_busy_off", 32'(mv_busy), 32'd0);
    reset_begin = 1'b0;
    watch(100);
    chk("rp_quiet_tx", 32'(en_cnt), 32'd0);
    chk("rp_no_done", 32'(v_n + r_n), 32'd0);

    // Verify timer: done exactly 100 cycles after the start pulse
    verify_timer_start = 1'b1;
    tick();
    verify_timer_start = 1'b0;
    timer_window(2, 99);
    chk("vt_early", 32'(hits), 32'd0);
    tick();
    chk("vt_done_at_100", 32'(verify_timer_done), 32'd1);
    timer_window(101, 110);
    chk("vt_done_held", 32'(hits), 32'd10);

    // Reload at cycle 50 moves expiry to cycle 150
    verify_timer_start = 1'b1;
    tick();
    verify_timer_start = 1'b0;
    chk("vt_clear_on_start", 32'(verify_timer_done), 32'd0);
    timer_window(2, 50);
    verify_timer_start = 1'b1;
    tick();
    verify_timer_start = 1'b0;
    timer_window(52, 149);
    chk("vt_reload_early", 32'(hits), 32'd0);
    tick();
    chk("vt_reload_at_150", 32'(verify_timer_done), 32'd1);

    // Reset at cycle 20 kills the timer
    verify_timer_start = 1'b1;
    tick();
    verify_timer_start = 1'b0;
    timer_window(2, 20);
    reset_begin = 1'b1;
    tick();
    reset_begin = 1'b0;
    timer_window(22, 160);
    chk("vt_reset_kills", 32'(hits), 32'd0);

    // link_fail at cycle 30 kills the timer
    verify_timer_start = 1'b1;
    tick();
    verify_timer_start = 1'b0;
    timer_window(2, 30);
    link_fail = 1'b1;
    tick();
    link_fail = 1'b0;
    timer_window(32, 160);
    chk("vt_link_fail_kills", 32'(hits), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
